// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: holds one decoded instruction, resolves MEM/WB forwarding,
// holds a consumer back for one cycle behind an in-flight load, and supports flush.
module ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_opselect,
    input  logic [RW-1:0] in_rs_addr,
    input  logic [RW-1:0] in_rt_addr,
    input  logic [DW-1:0] in_rs_data,
    input  logic [DW-1:0] in_rt_data,
    input  logic [DW-1:0] in_imm,
    input  logic          in_use_imm,
    input  logic [RW-1:0] in_rd_addr,
    input  logic          in_reg_write,
    input  logic          in_mem_read,
    input  logic          fwd_mem_we,
    input  logic          fwd_mem_is_load,
    input  logic [RW-1:0] fwd_mem_addr,
    input  logic [DW-1:0] fwd_mem_data,
    input  logic          fwd_wb_we,
    input  logic [RW-1:0] fwd_wb_addr,
    input  logic [DW-1:0] fwd_wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_opselect,
    output logic [DW-1:0] out_x,
    output logic [DW-1:0] out_y,
    output logic [RW-1:0] out_rd_addr,
    output logic          out_reg_write,
    output logic          out_mem_read,
    output logic [CW-1:0] stall_cnt
);

    logic          held_valid;
    logic [3:0]    opselect_q;
    logic [RW-1:0] rs_q, rt_q, rd_q;
    logic [DW-1:0] x_val, y_val;
    logic          use_imm_q, reg_write_q, mem_read_q;
    logic [CW-1:0] stall_q;

    logic          mem_rs, mem_rt, wb_rs, wb_rt, rt_src;
    logic          in_wb_rs, in_wb_rt;
    logic [DW-1:0] x_fwd, y_fwd, cap_x, cap_y;
    logic          pending, consume, capture;

    always_comb begin
        mem_rs   = fwd_mem_we && (fwd_mem_addr == rs_q) && (rs_q != '0);
        mem_rt   = fwd_mem_we && (fwd_mem_addr == rt_q) && (rt_q != '0);
        wb_rs    = fwd_wb_we && (fwd_wb_addr == rs_q) && (rs_q != '0);
        wb_rt    = fwd_wb_we && (fwd_wb_addr == rt_q) && (rt_q != '0);
        rt_src   = ~use_imm_q;
        in_wb_rs = fwd_wb_we && (fwd_wb_addr == in_rs_addr) && (in_rs_addr != '0);
        in_wb_rt = fwd_wb_we && (fwd_wb_addr == in_rt_addr) && (in_rt_addr != '0);

        x_fwd = x_val;
        if (mem_rs && !fwd_mem_is_load) x_fwd = fwd_mem_data;
        else if (wb_rs)                 x_fwd = fwd_wb_data;

        y_fwd = y_val;
        if (rt_src) begin
            if (mem_rt && !fwd_mem_is_load) y_fwd = fwd_mem_data;
            else if (wb_rt)                 y_fwd = fwd_wb_data;
        end

        // A load still in MEM has no data yet; wait until it reaches WB.
        pending   = held_valid && fwd_mem_is_load && (mem_rs || (rt_src && mem_rt));
        out_valid = held_valid && !pending;
        consume   = out_valid && out_ready;
        in_ready  = !flush && (!held_valid || consume);
        capture   = in_valid && in_ready;

        cap_x = in_wb_rs ? fwd_wb_data : in_rs_data;
        cap_y = in_use_imm ? in_imm : (in_wb_rt ? fwd_wb_data : in_rt_data);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_valid  <= 1'b0;
            opselect_q  <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            x_val       <= '0;
            y_val       <= '0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            stall_q     <= '0;
        end else begin
            if (pending && !(&stall_q)) stall_q <= stall_q + 1'b1;

            if (flush) begin
                held_valid <= 1'b0;
            end else if (capture) begin
                held_valid  <= 1'b1;
                opselect_q  <= in_opselect;
                rs_q        <= in_rs_addr;
                rt_q        <= in_rt_addr;
                rd_q        <= in_rd_addr;
                x_val       <= cap_x;
                y_val       <= cap_y;
                use_imm_q   <= in_use_imm;
                reg_write_q <= in_reg_write;
                mem_read_q  <= in_mem_read;
            end else if (consume) begin
                held_valid <= 1'b0;
            end else if (held_valid) begin
                // Latch forwarded values so they outlive the producing instruction.
                x_val <= x_fwd;
                y_val <= y_fwd;
            end
        end
    end

    assign out_opselect  = opselect_q;
    assign out_x         = x_fwd;
    assign out_y         = y_fwd;
    assign out_rd_addr   = rd_q;
    assign out_reg_write = reg_write_q;
    assign out_mem_read  = mem_read_q;
    assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus randomized traffic checked
// against a transaction-level model of the held entry.
module tb_ex_operand_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready;
    logic [3:0]    in_opselect;
    logic [RW-1:0] in_rs_addr, in_rt_addr, in_rd_addr;
    logic [DW-1:0] in_rs_data, in_rt_data, in_imm;
    logic          in_use_imm, in_reg_write, in_mem_read;
    logic          fwd_mem_we, fwd_mem_is_load, fwd_wb_we;
    logic [RW-1:0] fwd_mem_addr, fwd_wb_addr;
    logic [DW-1:0] fwd_mem_data, fwd_wb_data;
    logic          out_valid, out_ready;
    logic [3:0]    out_opselect;
    logic [DW-1:0] out_x, out_y;
    logic [RW-1:0] out_rd_addr;
    logic          out_reg_write, out_mem_read;
    logic [CW-1:0] stall_cnt;

    ex_operand_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opselect(in_opselect),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd_addr(in_rd_addr),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_is_load(fwd_mem_is_load),
        .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_addr(fwd_wb_addr), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opselect(out_opselect),
        .out_x(out_x), .out_y(out_y), .out_rd_addr(out_rd_addr),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: the instruction currently held, as a record.
    typedef struct {
        logic          v;
        logic [3:0]    op;
        logic [RW-1:0] rs, rt, rd;
        logic [DW-1:0] x, y;
        logic          imm, rw, mr;
    } entry_t;

    entry_t m;
    int     m_stall;

    function automatic logic mem_hit(input logic [RW-1:0] s);
        return fwd_mem_we && fwd_mem_addr == s && s != 0;
    endfunction

    function automatic logic wb_hit(input logic [RW-1:0] s);
        return fwd_wb_we && fwd_wb_addr == s && s != 0;
    endfunction

    // Value an operand sees this cycle given the forwarding network.
    function automatic logic [DW-1:0] seen(input logic [RW-1:0] s, input logic [DW-1:0] held, input logic src);
        if (!src) return held;
        if (mem_hit(s) && !fwd_mem_is_load) return fwd_mem_data;
        if (wb_hit(s)) return fwd_wb_data;
        return held;
    endfunction

    function automatic logic m_pend();
        return m.v && fwd_mem_is_load && (mem_hit(m.rs) || (!m.imm && mem_hit(m.rt)));
    endfunction

    function automatic logic m_ov();
        return m.v && !m_pend();
    endfunction

    function automatic logic m_ir();
        return !flush && (!m.v || (m_ov() && out_ready));
    endfunction

    task automatic model_edge();
        logic pend, ov, ir;
        pend = m_pend();
        ov   = m_ov();
        ir   = m_ir();
        if (!rst_n) begin
            m = '{v: 1'b0, op: '0, rs: '0, rt: '0, rd: '0, x: '0, y: '0, imm: 1'b0, rw: 1'b0, mr: 1'b0};
            m_stall = 0;
        end else begin
            if (pend && m_stall < (1 << CW) - 1) m_stall++;
            if (flush) m.v = 1'b0;
            else if (in_valid && ir) begin
                m.v   = 1'b1;
                m.op  = in_opselect;
                m.rs  = in_rs_addr;
                m.rt  = in_rt_addr;
                m.rd  = in_rd_addr;
                m.imm = in_use_imm;
                m.rw  = in_reg_write;
                m.mr  = in_mem_read;
                m.x   = wb_hit(in_rs_addr) ? fwd_wb_data : in_rs_data;
                m.y   = in_use_imm ? in_imm : (wb_hit(in_rt_addr) ? fwd_wb_data : in_rt_data);
            end else if (ov && out_ready) m.v = 1'b0;
            else if (m.v) begin
                m.x = seen(m.rs, m.x, 1'b1);
                m.y = seen(m.rt, m.y, !m.imm);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_all();
        chk("out_valid", out_valid, m_ov());
        chk("in_ready", in_ready, m_ir());
        chk("stall_cnt", stall_cnt, m_stall);
        if (m.v) begin
            chk("out_x", out_x, seen(m.rs, m.x, 1'b1));
            chk("out_y", out_y, seen(m.rt, m.y, !m.imm));
            chk("out_opselect", out_opselect, m.op);
            chk("out_rd_addr", out_rd_addr, m.rd);
            chk("out_ctrl", {out_reg_write, out_mem_read}, {m.rw, m.mr});
        end
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_opselect = 0;
        in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0;
        in_rs_data = 0; in_rt_data = 0; in_imm = 0;
        in_use_imm = 0; in_reg_write = 0; in_mem_read = 0;
        fwd_mem_we = 0; fwd_mem_is_load = 0; fwd_mem_addr = 0; fwd_mem_data = 0;
        fwd_wb_we = 0; fwd_wb_addr = 0; fwd_wb_data = 0;
        out_ready = 1;
    endtask

    task automatic offer(input logic [RW-1:0] rs, input logic [DW-1:0] rsd,
                         input logic [RW-1:0] rt, input logic [DW-1:0] rtd);
        in_valid = 1; in_rs_addr = rs; in_rs_data = rsd; in_rt_addr = rt; in_rt_data = rtd;
    endtask

    task automatic randomize_inputs();
        rst_n           = ($urandom_range(0, 63) != 0);
        flush           = ($urandom_range(0, 15) == 0);
        in_valid        = ($urandom_range(0, 3) != 0);
        in_opselect     = 4'($urandom_range(0, 15));
        in_rs_addr      = 5'($urandom_range(0, 7));
        in_rt_addr      = 5'($urandom_range(0, 7));
        in_rd_addr      = 5'($urandom_range(0, 31));
        in_rs_data      = $urandom;
        in_rt_data      = $urandom;
        in_imm          = $urandom;
        in_use_imm      = ($urandom_range(0, 3) == 0);
        in_reg_write    = 1'($urandom_range(0, 1));
        in_mem_read     = 1'($urandom_range(0, 1));
        fwd_mem_we      = ($urandom_range(0, 1) == 0);
        fwd_mem_is_load = ($urandom_range(0, 2) == 0);
        fwd_mem_addr    = 5'($urandom_range(0, 7));
        fwd_mem_data    = $urandom;
        fwd_wb_we       = ($urandom_range(0, 1) == 0);
        fwd_wb_addr     = 5'($urandom_range(0, 7));
        fwd_wb_data     = $urandom;
        out_ready       = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        idle();
        rst_n = 0;
        m_stall = 0;
        m.v = 1'b0;
        cycle();
        cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_ctrl", {out_opselect, out_rd_addr, out_reg_write, out_mem_read}, 0);
        rst_n = 1;

        // single add
        offer(1, 5, 2, 7); in_rd_addr = 3; in_reg_write = 1;
        settle(); chk("add_in_ready0", in_ready, 1);
        cycle(); idle(); settle();
        chk("add_valid", out_valid, 1);
        chk("add_x", out_x, 5);
        chk("add_y", out_y, 7);
        chk("add_op", out_opselect, 0);
        chk("add_in_ready1", in_ready, 1);
        check_all();
        cycle();

        // forward priority
        out_ready = 0; offer(3, 32'h99, 2, 1); in_opselect = 4'h2;
        cycle(); in_valid = 0;
        fwd_mem_we = 1; fwd_mem_addr = 3; fwd_mem_data = 32'h10;
        fwd_wb_we = 1; fwd_wb_addr = 3; fwd_wb_data = 32'h20;
        settle(); chk("fwd_mem_prio", out_x, 32'h10); check_all();
        fwd_mem_we = 0;
        settle(); chk("fwd_wb", out_x, 32'h20); check_all();
        idle(); cycle();
        out_ready = 0; offer(0, 32'h33, 0, 1);
        cycle(); in_valid = 0;
        fwd_mem_we = 1; fwd_mem_addr = 0; fwd_mem_data = 32'hFF;
        fwd_wb_we = 1; fwd_wb_addr = 0; fwd_wb_data = 32'hFF;
        settle(); chk("fwd_r0", out_x, 32'h33); check_all();
        idle(); cycle();

        // load-use bubble
        offer(1, 1, 4, 32'h44);
        cycle(); in_valid = 0;
        fwd_mem_we = 1; fwd_mem_is_load = 1; fwd_mem_addr = 4; fwd_mem_data = 32'hDEAD;
        settle();
        chk("ld_valid0", out_valid, 0);
        chk("ld_ready0", in_ready, 0);
        check_all();
        cycle(); idle();
        fwd_wb_we = 1; fwd_wb_addr = 4; fwd_wb_data = 32'hAB;
        settle();
        chk("ld_stall", stall_cnt, 1);
        chk("ld_valid1", out_valid, 1);
        chk("ld_y", out_y, 32'hAB);
        check_all();
        cycle(); idle();

        // backpressure refresh
        out_ready = 0; offer(6, 32'h11, 2, 2);
        cycle(); in_valid = 0;
        fwd_wb_we = 1; fwd_wb_addr = 6; fwd_wb_data = 32'h55;
        settle(); chk("bp_ready1", in_ready, 0); check_all();
        cycle(); fwd_wb_we = 0;
        settle(); chk("bp_x2", out_x, 32'h55); chk("bp_ready2", in_ready, 0); check_all();
        cycle();
        chk("bp_x3", out_x, 32'h55); chk("bp_ready3", in_ready, 0); check_all();
        out_ready = 1; cycle();

        // flush with an offered instruction
        out_ready = 0; offer(1, 7, 2, 8);
        cycle(); in_rd_addr = 9; flush = 1;
        settle(); chk("fl_ready", in_ready, 0);
        cycle(); idle();
        settle(); chk("fl_valid", out_valid, 0); check_all();
        cycle(); chk("fl_nocapture", out_valid, 0);

        // immediate operand ignores a load on rt
        out_ready = 0; offer(1, 1, 5, 32'h77); in_use_imm = 1; in_imm = 32'hFFFFFFFC;
        cycle(); in_valid = 0;
        fwd_mem_we = 1; fwd_mem_is_load = 1; fwd_mem_addr = 5;
        settle();
        chk("imm_valid", out_valid, 1);
        chk("imm_y", out_y, 32'hFFFFFFFC);
        check_all();
        idle(); cycle();

        // reset in the middle of a stall
        offer(2, 2, 3, 3);
        cycle(); in_valid = 0;
        fwd_mem_we = 1; fwd_mem_is_load = 1; fwd_mem_addr = 2;
        settle(); chk("rs_stall_valid", out_valid, 0);
        cycle();
        rst_n = 0; cycle(); rst_n = 1; fwd_mem_we = 0;
        settle();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_stall", stall_cnt, 0);
        chk("mrst_x", out_x, 0);
        chk("mrst_y", out_y, 0);

        // stall counter saturation
        offer(2, 2, 3, 3);
        cycle(); in_valid = 0;
        fwd_mem_we = 1; fwd_mem_is_load = 1; fwd_mem_addr = 2;
        for (int i = 0; i < 18; i++) cycle();
        chk("sat_stall", stall_cnt, (1 << CW) - 1);
        chk("sat_valid", out_valid, 0);
        check_all();
        rst_n = 0; idle(); cycle(); rst_n = 1;

        for (int i = 0; i < 3000; i++) begin
            cycle();
            randomize_inputs();
            settle();
            check_all();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX boundary stage that feeds the ALU its opselect, x and y.
- Holds one decoded instruction and resolves operand forwarding from the MEM and WB stages.
- Holds the instruction back while a load result is still in flight.
- Exchanges data with decode and with the ALU/EX consumer over valid/ready handshakes, and supports flush.

Parameters:
- DW, 32, datapath width
- RW, 5, register-address width
- CW, 16, stall-counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- flush  in  1  discard the held entry (branch/exception)
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_opselect  in  4  ALU operation code
- in_rs_addr, in_rt_addr  in  RW  source register numbers
- in_rs_data, in_rt_data  in  DW  register-file read data
- in_imm  in  DW  sign-extended immediate
- in_use_imm  in  1  1: y = imm, rt is not a source
- in_rd_addr  in  RW  destination register
- in_reg_write, in_mem_read  in  1  control passed through
- fwd_mem_we, fwd_mem_is_load  in  1  MEM-stage writes a register / is a load
- fwd_mem_addr  in  RW; fwd_mem_data  in  DW
- fwd_wb_we  in  1; fwd_wb_addr  in  RW; fwd_wb_data  in  DW
- out_valid  out  1  operands are resolved and valid for the ALU
- out_ready  in  1  ALU stage consumes
- out_opselect  out  4; out_x, out_y  out  DW
- out_rd_addr  out  RW; out_reg_write, out_mem_read  out  1
- stall_cnt  out  CW  saturating count of operand-wait cycles

Behaviour:
- Reset (rst_n=0 at a clk edge): held_valid=0, all stored fields=0, stall_cnt=0, all outputs=0.
- Storage: one entry holding opselect, rs/rt addr, x_val, y_val, use_imm, rd, reg_write, mem_read.
- Capture: on in_valid & in_ready, latency 1 cycle to out_* (entry visible the next cycle).
  - x_val = in_rs_data.
  - y_val = in_imm if in_use_imm, else in_rt_data.
- in_ready = ~flush & (~held_valid | (out_valid & out_ready)). Back-to-back throughput is 1/cycle.
- Forward match for source s:
  - MEM match: fwd_mem_we & fwd_mem_addr==s & s!=0.
  - WB match: fwd_wb_we & fwd_wb_addr==s & s!=0.
  - MEM has priority over WB.
  - Register 0 is never forwarded.
  - rt is not a source when use_imm=1.
- Combinational outputs while held:
  - out_x = MEM data if MEM-match(rs) & ~fwd_mem_is_load; else WB data if WB-match(rs); else x_val.
  - out_y uses the same rule for rt.
- pending = held_valid & ((MEM-match(rs) & fwd_mem_is_load) | (rt is a source & MEM-match(rt) & fwd_mem_is_load)).
- out_valid = held_valid & ~pending.
- Hold refresh: each cycle the entry stays (held_valid & ~(out_valid & out_ready)), any operand with an active non-load match is overwritten with its forwarded value. Forwarded data therefore survives the producer retiring.
- Loads: a load matching in MEM blocks out_valid. The next cycle the load sits in WB; its WB match forwards and refreshes the operand, and out_valid rises. This gives exactly one bubble.
- Capture-time forwarding: WB-match at capture is also applied to x_val/y_val, so a register-file write in the same cycle is not lost. MEM-match at capture is not applied here; it is handled by the output mux on the next cycle.
- Flush:
  - held_valid<=0 at the edge; out_valid=0 in the following cycle.
  - in_ready=0 during flush, so nothing is captured.
  - Flush while pending also clears the entry.
- Simultaneous consume and capture: the new entry replaces the old at the same edge; no bubble.
- stall_cnt increments on each cycle with held_valid & pending and saturates at all-ones. It is cleared only by reset.
- Outputs with held_valid=0: out_valid=0; out_* hold their last values (don't-care).

Test Plan:
1. Reset then a single add: rs=1 (data 5), rt=2 (data 7), opsel 0000, no forwarding, out_ready=1 → the next cycle out_valid=1, x=5, y=7, opsel=0000; in_ready stays 1.
2. Forward priority: rs=3 with MEM(we, addr3, 0x10) and WB(we, addr3, 0x20) both active → out_x=0x10. With MEM inactive → out_x=0x20. With addr=0 and data 0xFF → out_x = the register-file value.
3. Load-use: held rt=4, MEM is a load to r4 → out_valid=0 and in_ready=0 for one cycle, stall_cnt=1. The next cycle WB(r4, 0xAB) → out_valid=1, out_y=0xAB.
4. Backpressure refresh: out_ready=0 for 3 cycles. WB forwards r6=0x55 only in cycle 1 to held rs=6 → in cycle 3 out_x=0x55; in_ready=0 throughout.
5. Flush: entry held with out_ready=0; assert flush along with in_valid → the next cycle out_valid=0, and the offered instruction is not captured (in_ready was 0).
6. Immediate operand: use_imm=1, imm=0xFFFFFFFC, MEM load to rt's address → no stall, out_y=0xFFFFFFFC. Also sync reset asserted mid-stall → all outputs 0 and stall_cnt=0 the next cycle.
